// File: rtl/raycast_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raycast_pkg                                                              |
// | Shared widths, saturation limits and sweep FSM encoding.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package raycast_pkg;

  localparam int X_W     = 14;
  localparam int Y_W     = 13;
  localparam int GRID_X_W = 6;
  localparam int GRID_Y_W = 5;
  localparam int ANGLE_W = 8;
  localparam int ACC_W   = 16;
  localparam int COL_W   = 7;
  localparam int CYC_W   = 10;
  localparam logic [CYC_W-1:0] CYC_SAT = 10'd1023;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_WAIT_RAY = 3'd2,
    ST_EMIT     = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/raycast_sweeper_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raycast_sweeper_if                                                       |
// | Frame request, ray-engine handshake and column-result stream.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface raycast_sweeper_if;
  import raycast_pkg::*;

  logic                frame_start;
  logic [X_W-1:0]      player_x;
  logic [Y_W-1:0]      player_y;
  logic [ANGLE_W-1:0]  heading;
  logic                ray_start;
  logic [X_W-1:0]      ray_x;
  logic [Y_W-1:0]      ray_y;
  logic [ANGLE_W-1:0]  ray_angle;
  logic                ray_done;
  logic [GRID_X_W-1:0] ray_result_x;
  logic [GRID_Y_W-1:0] ray_result_y;
  logic                col_valid;
  logic                col_ready;
  logic [COL_W-1:0]    col_index;
  logic [GRID_X_W-1:0] col_hit_x;
  logic [GRID_Y_W-1:0] col_hit_y;
  logic [CYC_W-1:0]    col_cycles;
  logic                busy;
  logic                frame_done;

  modport master (
    input  frame_start, player_x, player_y, heading,
           ray_done, ray_result_x, ray_result_y, col_ready,
    output ray_start, ray_x, ray_y, ray_angle,
           col_valid, col_index, col_hit_x, col_hit_y, col_cycles,
           busy, frame_done
  );

  modport slave (
    output frame_start, player_x, player_y, heading,
           ray_done, ray_result_x, ray_result_y, col_ready,
    input  ray_start, ray_x, ray_y, ray_angle,
           col_valid, col_index, col_hit_x, col_hit_y, col_cycles,
           busy, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/sweep_angle_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_angle_gen                                                          |
// | 8.8 fixed-point ray angle accumulator: load at frame start, step per col.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sweep_angle_gen
  import raycast_pkg::*;
#(
  parameter logic [ACC_W-1:0] ANGLE_STEP = 16'h0066
) (
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic               load,
  input  wire logic               step,
  input  wire logic [ANGLE_W-1:0] load_angle,
  output      logic [ANGLE_W-1:0] ray_angle
);

  logic [ACC_W-1:0] angle_acc_q, angle_acc_d;

  // Addition is deliberately modulo 2^16 so the angle wraps around the circle.
  always_comb begin
    angle_acc_d = angle_acc_q;
    if (load) begin
      angle_acc_d = {load_angle, 8'h00};
    end else if (step) begin
      angle_acc_d = angle_acc_q + ANGLE_STEP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      angle_acc_q <= '0;
    end else begin
      angle_acc_q <= angle_acc_d;
    end
  end

  assign ray_angle = angle_acc_q[ACC_W-1:ACC_W-ANGLE_W];

endmodule
`default_nettype wire

// File: rtl/raycast_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raycast_sweeper                                                          |
// | Sequences one ray per screen column and streams per-column hit results.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module raycast_sweeper
  import raycast_pkg::*;
#(
  parameter int                 NUM_COLS   = 80,
  parameter logic [ACC_W-1:0]   ANGLE_STEP = 16'h0066,
  parameter logic [ANGLE_W-1:0] HALF_FOV   = 8'd16
) (
  input wire logic       clock,
  input wire logic       reset,
  raycast_sweeper_if.master bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  state_t              state_q, state_d;
  logic                ray_start_q, ray_start_d;
  logic                col_valid_q, col_valid_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [X_W-1:0]      ray_x_q, ray_x_d;
  logic [Y_W-1:0]      ray_y_q, ray_y_d;
  logic [COL_W-1:0]    col_index_q, col_index_d;
  logic [GRID_X_W-1:0] hit_x_q, hit_x_d;
  logic [GRID_Y_W-1:0] hit_y_q, hit_y_d;
  logic [CYC_W-1:0]    cnt_q, cnt_d;
  logic [CYC_W-1:0]    col_cycles_q, col_cycles_d;
  logic [CYC_W:0]      cnt_inc;
  logic [CYC_W-1:0]    cnt_sat;
  logic                angle_load, angle_step;

  always_comb begin
    state_d      = state_q;
    ray_x_d      = ray_x_q;
    ray_y_d      = ray_y_q;
    col_index_d  = col_index_q;
    hit_x_d      = hit_x_q;
    hit_y_d      = hit_y_q;
    cnt_d        = cnt_q;
    col_cycles_d = col_cycles_q;
    angle_load   = 1'b0;
    angle_step   = 1'b0;
    cnt_inc      = {1'b0, cnt_q} + 1'b1;
    cnt_sat      = (cnt_inc > {1'b0, CYC_SAT}) ? CYC_SAT : cnt_inc[CYC_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          ray_x_d     = bus.player_x;
          ray_y_d     = bus.player_y;
          col_index_d = '0;
          angle_load  = 1'b1;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_RAY;
      end
      ST_WAIT_RAY: begin
        // The done cycle itself is counted, hence counter+1.
        if (bus.ray_done) begin
          hit_x_d      = bus.ray_result_x;
          hit_y_d      = bus.ray_result_y;
          col_cycles_d = cnt_sat;
          state_d      = ST_EMIT;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      ST_EMIT: begin
        if (bus.col_ready) begin
          if (col_index_q == LAST_COL) begin
            state_d = ST_FINISH;
          end else begin
            col_index_d = col_index_q + 1'b1;
            angle_step  = 1'b1;
            state_d     = ST_LAUNCH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Status outputs are decoded from the next state so they register in step with it.
    ray_start_d  = (state_d == ST_LAUNCH);
    col_valid_d  = (state_d == ST_EMIT);
    frame_done_d = (state_d == ST_FINISH);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ray_start_q  <= 1'b0;
      col_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ray_x_q      <= '0;
      ray_y_q      <= '0;
      col_index_q  <= '0;
      hit_x_q      <= '0;
      hit_y_q      <= '0;
      cnt_q        <= '0;
      col_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      ray_start_q  <= ray_start_d;
      col_valid_q  <= col_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      ray_x_q      <= ray_x_d;
      ray_y_q      <= ray_y_d;
      col_index_q  <= col_index_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
      cnt_q        <= cnt_d;
      col_cycles_q <= col_cycles_d;
    end
  end

  sweep_angle_gen #(
    .ANGLE_STEP (ANGLE_STEP)
  ) u_angle_gen (
    .clock      (clock),
    .reset      (reset),
    .load       (angle_load),
    .step       (angle_step),
    .load_angle (bus.heading - HALF_FOV),
    .ray_angle  (bus.ray_angle)
  );

  assign bus.ray_start  = ray_start_q;
  assign bus.ray_x      = ray_x_q;
  assign bus.ray_y      = ray_y_q;
  assign bus.col_valid  = col_valid_q;
  assign bus.col_index  = col_index_q;
  assign bus.col_hit_x  = hit_x_q;
  assign bus.col_hit_y  = hit_y_q;
  assign bus.col_cycles = col_cycles_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_raycast_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_raycast_sweeper                                                       |
// | Directed + randomized frames against a column-level reference model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_raycast_sweeper;
  import raycast_pkg::*;

  localparam int          NC   = 4;
  localparam logic [15:0] STEP = 16'h0100;
  localparam logic [7:0]  HF   = 8'd2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  raycast_sweeper_if bus();

  raycast_sweeper #(
    .NUM_COLS   (NC),
    .ANGLE_STEP (STEP),
    .HALF_FOV   (HF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int delays[NC];
  int bp_col, bp_len, perturb_col, abort_col;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Angle of column i, straight from the 8.8 turn arithmetic.
  function automatic logic [7:0] model_angle(input logic [7:0] hdg, input int i);
    int a;
    a = (int'(hdg) - int'(HF)) * 256 + i * int'(STEP);
    a = ((a % 65536) + 65536) % 65536;
    return 8'(a / 256);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " pos"}, {bus.ray_x, bus.ray_y}, '0);
    chk({tag, " ctl"}, {bus.ray_start, bus.ray_angle, bus.col_valid, bus.col_index,
                       bus.col_hit_x, bus.col_hit_y, bus.col_cycles, bus.busy,
                       bus.frame_done}, '0);
  endtask

  task automatic recover();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ray_done = 1'b0;
    bus.col_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] hdg);
    logic [13:0] px;
    logic [12:0] py;
    logic [5:0]  hx;
    logic [4:0]  hy;
    logic [9:0]  ecyc;
    bit          got;
    px = 14'($urandom);
    py = 13'($urandom);
    bus.player_x = px;
    bus.player_y = py;
    bus.heading  = hdg;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    chk("busy after start", bus.busy, 1);
    for (int i = 0; i < NC; i++) begin
      got = 0;
      for (int k = 0; k < 8; k++) begin
        if (bus.ray_start === 1'b1) begin
          got = 1;
          break;
        end
        tick();
      end
      chk($sformatf("ray_start c%0d", i), got, 1);
      if (!got) begin
        recover();
        return;
      end
      chk($sformatf("origin c%0d", i), {bus.ray_x, bus.ray_y}, {px, py});
      chk($sformatf("angle c%0d", i), bus.ray_angle, model_angle(hdg, i));
      tick();
      chk($sformatf("start pulse c%0d", i), bus.ray_start, 0);
      if (i == abort_col) begin
        tick();
        #2 reset = 1'b1;
        #1 check_zero("async reset");
        tick();
        tick();
        reset = 1'b0;
        check_zero("after reset");
        return;
      end
      for (int j = 1; j < delays[i]; j++) begin
        if (i == perturb_col && j == 1) begin
          bus.frame_start = 1'b1;
          bus.heading = 8'($urandom);
          bus.player_x = 14'($urandom);
          bus.player_y = 13'($urandom);
        end
        tick();
        bus.frame_start = 1'b0;
      end
      chk($sformatf("held c%0d", i), {bus.ray_x, bus.ray_y, bus.ray_angle},
          {px, py, model_angle(hdg, i)});
      hx = 6'($urandom);
      hy = 5'($urandom);
      bus.ray_result_x = hx;
      bus.ray_result_y = hy;
      bus.ray_done = 1'b1;
      tick();
      bus.ray_done = 1'b0;
      bus.ray_result_x = 6'($urandom);
      bus.ray_result_y = 5'($urandom);
      ecyc = (delays[i] > 1023) ? 10'd1023 : 10'(delays[i]);
      chk($sformatf("column c%0d", i),
          {bus.col_valid, bus.col_index, bus.col_hit_x, bus.col_hit_y, bus.col_cycles},
          {1'b1, 7'(i), hx, hy, ecyc});
      if (i == bp_col) begin
        for (int n = 0; n < bp_len; n++) begin
          if (n == 0) bus.ray_done = 1'b1;
          tick();
          bus.ray_done = 1'b0;
          chk($sformatf("stall c%0d n%0d", i, n),
              {bus.col_valid, bus.col_index, bus.col_hit_x, bus.col_hit_y, bus.col_cycles,
               bus.ray_start},
              {1'b1, 7'(i), hx, hy, ecyc, 1'b0});
        end
      end
      bus.col_ready = 1'b1;
      tick();
      bus.col_ready = 1'b0;
      if (i < NC - 1) begin
        chk($sformatf("relaunch c%0d", i), {bus.ray_start, bus.col_valid, bus.frame_done},
            3'b100);
      end else begin
        chk("frame_done pulse", {bus.frame_done, bus.col_valid, bus.busy}, 3'b101);
        tick();
        chk("frame end idle", {bus.frame_done, bus.busy, bus.ray_start}, 3'b000);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.player_x = '0;
    bus.player_y = '0;
    bus.heading = '0;
    bus.ray_done = 1'b0;
    bus.ray_result_x = '0;
    bus.ray_result_y = '0;
    bus.col_ready = 1'b0;
    bp_col = -1; bp_len = 0; perturb_col = -1; abort_col = -1;
    tick();
    tick();
    check_zero("reset state");
    reset = 1'b0;
    tick();

    delays = '{5, 5, 5, 5};
    run_frame(8'd10);
    tick();

    run_frame(8'd1);
    tick();

    bp_col = 1; bp_len = 10;
    run_frame(8'($urandom));
    bp_col = -1;
    tick();

    delays = '{2000, 1, 5, 5};
    run_frame(8'd10);
    tick();

    delays = '{5, 5, 4, 5};
    perturb_col = 2;
    run_frame(8'd10);
    perturb_col = -1;
    tick();

    abort_col = 1;
    run_frame(8'd10);
    abort_col = -1;
    tick();
    delays = '{3, 5, 1, 2};
    run_frame(8'd200);
    tick();

    for (int f = 0; f < 3; f++) begin
      foreach (delays[c]) delays[c] = $urandom_range(12, 1);
      bp_col = $urandom_range(NC - 1, 0);
      bp_len = $urandom_range(5, 1);
      run_frame(8'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/raycast_sweeper.md
RAYCAST_SWEEPER -- requirements
Module: raycast_sweeper

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_COLS, default 80, giving the number of screen columns (rays) per frame, range 1..128.
REQ-002 The block SHALL have parameter ANGLE_STEP, default 16'h0066, giving the per-column angle increment in 8.8 fixed-point angle units (256 units = full turn).
REQ-003 The block SHALL have parameter HALF_FOV, default 8'd16, giving the angle offset of column 0 below heading.
Ports (name, direction, width, meaning):
REQ-004 The block SHALL have these ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- frame_start  in  1  request a sweep; sampled in IDLE only
- player_x  in  14  player x coordinate
- player_y  in  13  player y coordinate
- heading  in  8  player view angle
- ray_start  out  1  one-cycle pulse launching the ray engine
- ray_x  out  14  ray origin x, held stable from ray_start until ray_done
- ray_y  out  13  ray origin y, held stable likewise
- ray_angle  out  8  ray angle, held stable likewise
- ray_done  in  1  one-cycle completion pulse from the ray engine
- ray_result_x  in  6  grid x of hit cell, valid in the ray_done cycle
- ray_result_y  in  5  grid y of hit cell, valid in the ray_done cycle
- col_valid  out  1  column result available
- col_ready  in  1  consumer accepts column result when high with col_valid
- col_index  out  7  column number 0..NUM_COLS-1
- col_hit_x  out  6  captured ray_result_x
- col_hit_y  out  5  captured ray_result_y
- col_cycles  out  10  ray latency in cycles, saturating at 1023
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last column is accepted

Function
REQ-005 The FSM SHALL have states IDLE, LAUNCH, WAIT_RAY, EMIT, FINISH.
REQ-006 In IDLE with frame_start=1, the block SHALL latch player_x, player_y, and heading into ray_x and ray_y, SHALL set angle_acc = {heading - HALF_FOV, 8'h00} mod 2^16, SHALL set col_index=0, and SHALL go to LAUNCH.
REQ-007 LAUNCH SHALL last exactly one cycle, SHALL assert ray_start, SHALL clear the cycle counter, and SHALL go to WAIT_RAY.
REQ-008 ray_angle SHALL equal angle_acc[15:8] at all times; angle arithmetic SHALL wrap mod 256 without saturation.
REQ-009 In WAIT_RAY the cycle counter SHALL increment each cycle, saturating at 1023; on ray_done it SHALL capture the hit coordinates, set col_cycles = counter+1 (saturated), and go to EMIT.
REQ-010 col_cycles SHALL count cycles from the cycle after ray_start to the ray_done cycle, inclusive.
REQ-011 In EMIT, col_valid=1 and col_* SHALL stay stable until col_ready=1; ray_start SHALL NOT be asserted while in EMIT.
REQ-012 On the EMIT acceptance cycle with col_index < NUM_COLS-1, the block SHALL increment col_index, add ANGLE_STEP to angle_acc, and go to LAUNCH.
REQ-013 On the EMIT acceptance cycle with col_index = NUM_COLS-1, the block SHALL go to FINISH.
REQ-014 FINISH SHALL assert frame_done for one cycle and then go to IDLE.
REQ-015 frame_start outside IDLE SHALL be ignored, with no effect on the sweep in progress.
REQ-016 player_x, player_y, and heading changes during a sweep SHALL NOT affect the current frame.
REQ-017 A ray_done received outside WAIT_RAY SHALL be ignored.
REQ-018 The minimum spacing between successive ray_start pulses SHALL be 3 cycles (LAUNCH, WAIT_RAY, EMIT with col_ready=1).
REQ-019 A ray_done in the cycle immediately after LAUNCH SHALL be accepted and SHALL give col_cycles=1.

Reset
REQ-020 On reset assertion the block SHALL immediately go to IDLE, asynchronously.
REQ-021 During reset the block SHALL hold all outputs at 0: ray_start, ray_x, ray_y, ray_angle, col_valid, col_index, col_hit_x, col_hit_y, col_cycles, busy, and frame_done.
REQ-022 Reset mid-ray SHALL abandon the frame and SHALL NOT emit a partial column; the ray engine shares the same reset.

Structure
REQ-023 A shared package raycast_pkg SHALL hold the coordinate widths (14/13), grid widths (6/5), the angle width (8), the col_cycles width and saturation value, and the FSM state encoding.
REQ-024 A single sub-module sweep_angle_gen SHALL own angle_acc (load, step, ray_angle output); the ray engine SHALL be instantiated beside this block, not inside it.

Verification
REQ-025 The bench SHALL use NUM_COLS=4, ANGLE_STEP=16'h0100, HALF_FOV=2, heading=10, and a ray model that returns done 5 cycles after start: ray_angle sequence 8,9,10,11; col_cycles=5 for every column; one frame_done.
REQ-026 Angle wrap: with heading=1 and the same parameters, ray_angle SHALL be 255,0,1,2.
REQ-027 Backpressure: with col_ready low for 10 cycles on column 1, col_* SHALL stay stable, with no ray_start pulse until acceptance.
REQ-028 Saturation: with a ray model that delays done 2000 cycles, col_cycles SHALL be 1023; with done 1 cycle after start, col_cycles SHALL be 1.
REQ-029 frame_start pulsed at column 2, and heading changed mid-frame, SHALL have no effect; exactly NUM_COLS columns and one frame_done SHALL be produced.
REQ-030 Reset asserted in WAIT_RAY of column 1: outputs SHALL go to 0 asynchronously, and after release a new frame_start SHALL restart at col_index 0.
